// File: rtl/rv_alu_issue.sv
// rtl/rv_alu_issue.sv - ALU op decode and valid/ready issue stage with skid buffer
module rv_alu_issue (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [1:0]  aluop_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7_5_i,
    input  logic [63:0] op1_i,
    input  logic [63:0] op2_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [63:0] op1_o,
    output logic [63:0] op2_o,
    output logic [3:0]  op_sel_o,
    output logic        illegal_o
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_ILL = 4'b1111;

    logic        dec_ill;
    logic [3:0]  dec_sel;

    logic        out_valid_q, out_valid_d;
    logic [63:0] out_op1_q, out_op1_d;
    logic [63:0] out_op2_q, out_op2_d;
    logic [3:0]  out_sel_q, out_sel_d;
    logic        out_ill_q, out_ill_d;

    logic        skid_valid_q, skid_valid_d;
    logic [63:0] skid_op1_q, skid_op1_d;
    logic [63:0] skid_op2_q, skid_op2_d;
    logic [3:0]  skid_sel_q, skid_sel_d;
    logic        skid_ill_q, skid_ill_d;

    logic        accept;
    logic        out_free;

    // Translate the control-unit ALU class plus funct fields into the ALU opcode.
    always_comb begin
        dec_sel = OP_ILL;
        dec_ill = 1'b0;
        unique case (aluop_i)
            2'b00: dec_sel = OP_ADD;
            2'b01: dec_sel = OP_SUB;
            default: begin
                unique case (funct3_i)
                    3'b000: begin
                        // I-type has no SUB; bit 30 is part of the immediate there.
                        if (aluop_i == 2'b10 && funct7_5_i) dec_sel = OP_SUB;
                        else                                dec_sel = OP_ADD;
                    end
                    3'b111: dec_sel = OP_AND;
                    3'b110: dec_sel = OP_OR;
                    3'b010: dec_sel = OP_SLT;
                    default: begin
                        dec_sel = OP_ILL;
                        dec_ill = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // Next-state for the OUT register and the skid entry; flush overrides everything.
    always_comb begin
        accept       = valid_i && !skid_valid_q;
        out_free     = !out_valid_q || ready_i;

        out_valid_d  = out_valid_q;
        out_op1_d    = out_op1_q;
        out_op2_d    = out_op2_q;
        out_sel_d    = out_sel_q;
        out_ill_d    = out_ill_q;
        skid_valid_d = skid_valid_q;
        skid_op1_d   = skid_op1_q;
        skid_op2_d   = skid_op2_q;
        skid_sel_d   = skid_sel_q;
        skid_ill_d   = skid_ill_q;

        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free && skid_valid_q) begin
            out_valid_d = 1'b1;
            out_op1_d   = skid_op1_q;
            out_op2_d   = skid_op2_q;
            out_sel_d   = skid_sel_q;
            out_ill_d   = skid_ill_q;
            if (accept) begin
                skid_valid_d = 1'b1;
                skid_op1_d   = op1_i;
                skid_op2_d   = op2_i;
                skid_sel_d   = dec_sel;
                skid_ill_d   = dec_ill;
            end else begin
                skid_valid_d = 1'b0;
            end
        end else if (out_free) begin
            if (accept) begin
                out_valid_d = 1'b1;
                out_op1_d   = op1_i;
                out_op2_d   = op2_i;
                out_sel_d   = dec_sel;
                out_ill_d   = dec_ill;
            end else if (ready_i) begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_op1_d   = op1_i;
            skid_op2_d   = op2_i;
            skid_sel_d   = dec_sel;
            skid_ill_d   = dec_ill;
        end
    end

    // State registers; reset also zeroes data so nothing downstream sees X.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q  <= 1'b0;
            out_op1_q    <= '0;
            out_op2_q    <= '0;
            out_sel_q    <= '0;
            out_ill_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_op1_q   <= '0;
            skid_op2_q   <= '0;
            skid_sel_q   <= '0;
            skid_ill_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_op1_q    <= out_op1_d;
            out_op2_q    <= out_op2_d;
            out_sel_q    <= out_sel_d;
            out_ill_q    <= out_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_op1_q   <= skid_op1_d;
            skid_op2_q   <= skid_op2_d;
            skid_sel_q   <= skid_sel_d;
            skid_ill_q   <= skid_ill_d;
        end
    end

    assign ready_o   = !skid_valid_q;
    assign valid_o   = out_valid_q;
    assign op1_o     = out_op1_q;
    assign op2_o     = out_op2_q;
    assign op_sel_o  = out_sel_q;
    assign illegal_o = out_ill_q;

endmodule

// File: doc/rv_alu_issue.md
# rv_alu_issue

Execute-stage issue unit that feeds the 64-bit ALU (`rv_alu`). It decodes the control-unit ALU class (`aluop`) together with `funct3`/`funct7[5]` into the ALU's 4-bit `op_sel` encoding, and registers operands and opcode in a valid/ready pipeline stage. A skid buffer lets the upstream `ready_o` come from a register. It sits between ID and EX and drives the ALU inputs directly.

## Interface

- No parameters; data width fixed at 64.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  asynchronous reset, active-high.
- `flush_i`  in  1  synchronous pipeline flush (branch/trap).
- `valid_i`  in  1  upstream request valid.
- `ready_o`  out  1  upstream may present; registered, `ready_o = !skid_valid`.
- `aluop_i`  in  2  ALU class: 00 load/store, 01 branch, 10 R-type, 11 I-type.
- `funct3_i`  in  3  instruction funct3.
- `funct7_5_i`  in  1  instruction bit 30.
- `op1_i`, `op2_i`  in  64  operands.
- `valid_o`  out  1  ALU request valid.
- `ready_i`  in  1  downstream accepts.
- `op1_o`, `op2_o`  out  64  registered operands to ALU.
- `op_sel_o`  out  4  registered ALU opcode.
- `illegal_o`  out  1  registered; request carries an unsupported encoding.

## Operation

- ALU encodings: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111 (unsigned compare as the ALU implements), NOR 1100. This unit never generates NOR.
- Decode by `aluop_i`:
  - 00 → ADD.
  - 01 → SUB.
  - 10 decodes on `funct3_i`:
    - 000 → ADD if `funct7_5_i=0`, SUB if 1.
    - 111 → AND.
    - 110 → OR.
    - 010 → SLT.
    - Any other funct3 → illegal.
  - 11 decodes the same as 10, except 000 is always ADD (`funct7_5_i` ignored).
- Illegal requests still flow through the pipeline: `op_sel_o=4'b1111` and `illegal_o=1`. The ALU returns 0 for this code; the trap logic consumes `illegal_o`.
- Accept: a request transfers when `valid_i && ready_o` at a clock edge.
- Storage: output register (OUT) plus one skid entry (SKID). Each holds {op1, op2, op_sel, illegal, valid}.
- Per-edge rules, with `out_free = !valid_o || ready_i`:
  - `out_free` and SKID valid: SKID moves to OUT. An accepted request goes to SKID. Otherwise SKID is cleared.
  - `out_free` and SKID empty: an accepted request loads OUT. Otherwise `valid_o` clears if `ready_i`.
  - `!out_free` and accept: the request goes to SKID. SKID can only be empty here, since `ready_o=1`.
- `flush_i=1`: both valid bits clear at the edge. Any accept that cycle is discarded. Flush has priority over all rules above.
- Data fields of an invalid entry are don't-care but must not be X-propagating. Hold the last values.

## Timing

- Reset (async assert, held while `rst_i=1`): `valid_o=0`, `op1_o=0`, `op2_o=0`, `op_sel_o=0`, `illegal_o=0`, SKID invalid, `ready_o=1`.
- Latency: 1 cycle from accept to `valid_o`.
- Throughput: 1 request/cycle while `ready_i=1`.
- Backpressure:
  - The first stalled cycle absorbs one request into SKID.
  - `ready_o` drops in the following cycle.
  - `ready_o` returns 1 the cycle after SKID drains.
- Output stability: while `valid_o && !ready_i`, all outputs are stable.
- Ordering: strict FIFO, no drops except on flush.
- Reset mid-transfer: all in-flight entries are lost. No output is presented until a new accept.

## Test plan

- Reset, then `aluop=10`, `funct3=000`, `f7_5=1`, `op1=10`, `op2=3`, `ready_i=1` → next cycle `valid_o=1`, `op_sel_o=0110`, `illegal_o=0`, `op1_o=10`, `op2_o=3`.
- Decode sweep, all 2×8×2 combinations of `aluop` ∈ {10,11}, `funct3`, `f7_5` → codes per table above. E.g. `aluop=11`, `funct3=000`, `f7_5=1` → 0010. `funct3=001` → `op_sel_o=1111`, `illegal_o=1`. `aluop=00` → 0010 and `aluop=01` → 0110 regardless of funct fields.
- Backpressure:
  - Stimulus: stream A, B, C, D with `ready_i=0` from the cycle A appears.
  - Required: A held on outputs; B in SKID; `ready_o=0` one cycle later; C not accepted.
  - Then raise `ready_i`: outputs A, B, C, D in order, no loss or duplication, `ready_o` back to 1.
- Flush with SKID full and a concurrent `valid_i` → next cycle `valid_o=0`, `ready_o=1`. The next accepted request appears after 1 cycle.
- Async reset asserted mid-stall (between edges) → outputs go to reset values immediately, without waiting for a clock edge.
- Random valid/ready/flush for 10k cycles against a scoreboard → order preserved, flushed entries absent, outputs stable under stall.
